// File: rtl/sccb_slave_model.sv
// rtl/sccb_slave_model.sv - OV5640-style SCCB responder: 7-bit device, 16-bit register address, 8-bit data.
// Define SCCB_SLAVE_READ_EN to answer R/W=1 requests from the register file.
module sccb_slave_model #(
   parameter logic [6:0] DEV_ADDR    = 7'h3C,
   parameter int         REG_DEPTH   = 256,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rstn,
   input  logic        cmos_sclk,
   inout  wire         cmos_sdat,
   output logic        reg_wr_en,
   output logic [15:0] reg_wr_addr,
   output logic [7:0]  reg_wr_data,
   output logic        busy
);

   localparam int AW = $clog2(REG_DEPTH);

   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] DEV_ADDR_S = 4'd1;
   localparam logic [3:0] ACK_DEV   = 4'd2;
   localparam logic [3:0] ADDR_H    = 4'd3;
   localparam logic [3:0] ACK_H     = 4'd4;
   localparam logic [3:0] ADDR_L    = 4'd5;
   localparam logic [3:0] ACK_L     = 4'd6;
   localparam logic [3:0] WR_DATA   = 4'd7;
   localparam logic [3:0] ACK_WR    = 4'd8;
`ifdef SCCB_SLAVE_READ_EN
   localparam logic [3:0] RD_DATA   = 4'd9;
   localparam logic [3:0] RD_ACK    = 4'd10;
`endif
   localparam logic [3:0] WAIT_STOP = 4'd11;

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_d;
   logic                   r_sda_d;
   logic [3:0]             r_state;
   logic [3:0]             r_bit_cnt;
   logic [6:0]             r_shift;
   logic [15:0]            r_reg_addr;
   logic                   r_sda_oe;
   logic [7:0]             r_regfile [REG_DEPTH];

   logic                   w_scl;
   logic                   w_sda;
   logic                   w_scl_rise;
   logic                   w_scl_fall;
   logic                   w_start;
   logic                   w_stop;
   logic [7:0]             w_byte;
   logic [AW-1:0]          w_idx;

   assign cmos_sdat  = r_sda_oe ? 1'b0 : 1'bz;

   assign w_scl      = r_scl_sync[SYNC_STAGES-1];
   assign w_sda      = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
   assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
   assign w_byte     = {r_shift, w_sda};
   assign w_idx      = r_reg_addr[AW-1:0];

`ifdef SCCB_SLAVE_READ_EN
   logic       r_rw;
   logic [7:0] w_rd_byte;
   assign w_rd_byte = r_regfile[w_idx];
`endif

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         r_scl_sync  <= '1;
         r_sda_sync  <= '1;
         r_scl_d     <= 1'b1;
         r_sda_d     <= 1'b1;
         r_state     <= IDLE;
         r_bit_cnt   <= 4'd0;
         r_shift     <= 7'd0;
         r_reg_addr  <= 16'd0;
         r_sda_oe    <= 1'b0;
         reg_wr_en   <= 1'b0;
         reg_wr_addr <= 16'd0;
         reg_wr_data <= 8'd0;
         busy        <= 1'b0;
`ifdef SCCB_SLAVE_READ_EN
         r_rw        <= 1'b0;
`endif
         for (int i = 0; i < REG_DEPTH; i++) r_regfile[i] <= 8'd0;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], cmos_sclk};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], cmos_sdat};
         r_scl_d    <= w_scl;
         r_sda_d    <= w_sda;
         reg_wr_en  <= 1'b0;
         if (w_stop) begin
            r_state   <= IDLE;
            r_sda_oe  <= 1'b0;
            r_bit_cnt <= 4'd0;
            busy      <= 1'b0;
         end else if (w_start) begin
            r_state   <= DEV_ADDR_S;
            r_sda_oe  <= 1'b0;
            r_bit_cnt <= 4'd0;
         end else begin
            case (r_state)
               DEV_ADDR_S, ADDR_H, ADDR_L, WR_DATA: begin
                  if (w_scl_rise) begin
                     r_shift   <= w_byte[6:0];
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (r_bit_cnt == 4'd7) begin
                        case (r_state)
                           DEV_ADDR_S: begin
                              if (w_byte[7:1] != DEV_ADDR) r_state <= WAIT_STOP;
`ifdef SCCB_SLAVE_READ_EN
                              else begin
                                 r_state <= ACK_DEV;
                                 r_rw    <= w_byte[0];
                                 busy    <= 1'b1;
                              end
`else
                              else if (w_byte[0]) r_state <= WAIT_STOP;
                              else begin
                                 r_state <= ACK_DEV;
                                 busy    <= 1'b1;
                              end
`endif
                           end
                           ADDR_H: begin
                              r_reg_addr[15:8] <= w_byte;
                              r_state          <= ACK_H;
                           end
                           ADDR_L: begin
                              r_reg_addr[7:0] <= w_byte;
                              r_state         <= ACK_L;
                           end
                           default: begin
                              r_regfile[w_idx] <= w_byte;
                              reg_wr_en        <= 1'b1;
                              reg_wr_addr      <= r_reg_addr;
                              reg_wr_data      <= w_byte;
                              r_state          <= ACK_WR;
                           end
                        endcase
                     end
                  end
               end
               // bit counter 8 = ACK not yet driven, 9 = ACK on the bus
               ACK_DEV, ACK_H, ACK_L, ACK_WR: begin
                  if (w_scl_fall) begin
                     if (r_bit_cnt == 4'd8) begin
                        r_sda_oe  <= 1'b1;
                        r_bit_cnt <= 4'd9;
                     end else begin
                        r_sda_oe  <= 1'b0;
                        r_bit_cnt <= 4'd0;
                        case (r_state)
`ifdef SCCB_SLAVE_READ_EN
                           ACK_DEV: begin
                              if (r_rw) begin
                                 r_state  <= RD_DATA;
                                 r_shift  <= w_rd_byte[6:0];
                                 r_sda_oe <= ~w_rd_byte[7];
                              end else begin
                                 r_state <= ADDR_H;
                              end
                           end
`else
                           ACK_DEV: r_state <= ADDR_H;
`endif
                           ACK_H:   r_state <= ADDR_L;
                           ACK_L:   r_state <= WR_DATA;
                           default: begin
                              r_reg_addr <= r_reg_addr + 16'd1;
                              r_state    <= WR_DATA;
                           end
                        endcase
                     end
                  end
               end
`ifdef SCCB_SLAVE_READ_EN
               RD_DATA: begin
                  if (w_scl_rise) begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end else if (w_scl_fall) begin
                     if (r_bit_cnt == 4'd8) begin
                        r_sda_oe <= 1'b0;
                        r_state  <= RD_ACK;
                     end else begin
                        r_sda_oe <= ~r_shift[6];
                        r_shift  <= {r_shift[5:0], 1'b0};
                     end
                  end
               end
               RD_ACK: begin
                  if (w_scl_rise) begin
                     if (!w_sda) begin
                        r_reg_addr <= r_reg_addr + 16'd1;
                        r_bit_cnt  <= 4'd9;
                     end else begin
                        r_state <= WAIT_STOP;
                     end
                  end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
                     r_shift   <= w_rd_byte[6:0];
                     r_sda_oe  <= ~w_rd_byte[7];
                     r_bit_cnt <= 4'd0;
                     r_state   <= RD_DATA;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sccb_slave_model.sv
// tb/tb_sccb_slave_model.sv - directed bench for sccb_slave_model driving a bit-banged SCCB master.
module tb_sccb_slave_model;

   localparam int Q = 20;
   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_WAIT_STOP = 4'd11;

   logic        sys_clk = 1'b0;
   logic        sys_rstn;
   logic        scl;
   logic        m_oe;
   wire         sda;
   logic        reg_wr_en;
   logic [15:0] reg_wr_addr;
   logic [7:0]  reg_wr_data;
   logic        busy;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] q_addr[$];
   logic [7:0]  q_data[$];
   logic        mon_en = 1'b0;
   int          dut_low_cnt = 0;

   pullup (sda);
   assign sda = m_oe ? 1'b0 : 1'bz;

   always #5 sys_clk = ~sys_clk;

   sccb_slave_model dut (
      .sys_clk    (sys_clk),
      .sys_rstn   (sys_rstn),
      .cmos_sclk  (scl),
      .cmos_sdat  (sda),
      .reg_wr_en  (reg_wr_en),
      .reg_wr_addr(reg_wr_addr),
      .reg_wr_data(reg_wr_data),
      .busy       (busy)
   );

   always @(negedge sys_clk) begin
      if (reg_wr_en === 1'b1) begin
         q_addr.push_back(reg_wr_addr);
         q_data.push_back(reg_wr_data);
      end
      if (mon_en && !m_oe && sda === 1'b0) dut_low_cnt++;
   end

   task automatic wq(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic bus_start;
      m_oe = 1'b0; wq(Q); scl = 1'b1; wq(Q); m_oe = 1'b1; wq(Q); scl = 1'b0; wq(Q);
   endtask

   task automatic bus_stop;
      m_oe = 1'b1; wq(Q); scl = 1'b1; wq(Q); m_oe = 1'b0; wq(Q);
   endtask

   task automatic write_bit(input logic b);
      m_oe = ~b; wq(Q); scl = 1'b1; wq(2 * Q); scl = 1'b0; wq(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      m_oe = 1'b0; wq(Q); scl = 1'b1; wq(Q);
      ack = (sda === 1'b0);
      wq(Q); scl = 1'b0; wq(Q);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      m_oe = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         wq(Q); scl = 1'b1; wq(Q);
         d[i] = (sda !== 1'b0);
         wq(Q); scl = 1'b0; wq(Q);
      end
      write_bit(mack);
      m_oe = 1'b0;
   endtask

   task automatic test_reset;
      sys_rstn = 1'b0; scl = 1'b1; m_oe = 1'b0;
      wq(4);
      checks++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", reg_wr_en); end
      checks++; if (reg_wr_addr !== 16'h0000) begin errors++; $display("FAIL reset_wr_addr got %h want 0000", reg_wr_addr); end
      checks++; if (reg_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h want 00", reg_wr_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", sda); end
      checks++; if (dut.r_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.r_state, S_IDLE); end
      sys_rstn = 1'b1;
      wq(4);
   endtask

   task automatic test_single_write;
      logic [7:0] v[4];
      logic       ack;
      v = '{8'h78, 8'h30, 8'h08, 8'h82};
      q_addr.delete(); q_data.delete();
      bus_start();
      for (int i = 0; i < 4; i++) begin
         write_byte(v[i], ack);
         checks++; if (ack !== 1'b1) begin errors++; $display("FAIL single_ack%0d got %b want 1", i, ack); end
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hi got %b want 1", busy); end
      bus_stop();
      wq(4);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_lo got %b want 0", busy); end
      checks++; if (q_addr.size() != 1) begin errors++; $display("FAIL single_strobes got %0d want 1", q_addr.size()); end
      if (q_addr.size() >= 1) begin
         checks++; if (q_addr[0] !== 16'h3008) begin errors++; $display("FAIL single_addr got %h want 3008", q_addr[0]); end
         checks++; if (q_data[0] !== 8'h82) begin errors++; $display("FAIL single_data got %h want 82", q_data[0]); end
      end
      checks++; if (dut.r_regfile[8'h08] !== 8'h82) begin errors++; $display("FAIL single_reg got %h want 82", dut.r_regfile[8'h08]); end
   endtask

   task automatic test_burst_wrap;
      logic [7:0] v[5];
      logic       ack;
      v = '{8'h78, 8'hFF, 8'hFF, 8'h11, 8'h22};
      q_addr.delete(); q_data.delete();
      bus_start();
      for (int i = 0; i < 5; i++) begin
         write_byte(v[i], ack);
         checks++; if (ack !== 1'b1) begin errors++; $display("FAIL burst_ack%0d got %b want 1", i, ack); end
      end
      bus_stop();
      wq(4);
      checks++; if (q_addr.size() != 2) begin errors++; $display("FAIL burst_strobes got %0d want 2", q_addr.size()); end
      if (q_addr.size() >= 2) begin
         checks++; if (q_addr[0] !== 16'hFFFF) begin errors++; $display("FAIL burst_addr0 got %h want ffff", q_addr[0]); end
         checks++; if (q_data[0] !== 8'h11) begin errors++; $display("FAIL burst_data0 got %h want 11", q_data[0]); end
         checks++; if (q_addr[1] !== 16'h0000) begin errors++; $display("FAIL burst_addr1 got %h want 0000", q_addr[1]); end
         checks++; if (q_data[1] !== 8'h22) begin errors++; $display("FAIL burst_data1 got %h want 22", q_data[1]); end
      end
      checks++; if (dut.r_regfile[8'hFF] !== 8'h11) begin errors++; $display("FAIL burst_regff got %h want 11", dut.r_regfile[8'hFF]); end
      checks++; if (dut.r_regfile[8'h00] !== 8'h22) begin errors++; $display("FAIL burst_reg00 got %h want 22", dut.r_regfile[8'h00]); end
   endtask

   task automatic test_bad_device;
      logic [7:0] bad[4];
      logic [7:0] good[4];
      logic       ack;
      bad  = '{8'h7A, 8'h30, 8'h08, 8'h55};
      good = '{8'h78, 8'h10, 8'h00, 8'hA5};
      q_addr.delete(); q_data.delete();
      dut_low_cnt = 0; mon_en = 1'b1;
      bus_start();
      for (int i = 0; i < 4; i++) begin
         write_byte(bad[i], ack);
         checks++; if (ack !== 1'b0) begin errors++; $display("FAIL baddev_nack%0d got %b want 0", i, ack); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL baddev_busy got %b want 0", busy); end
      bus_stop();
      mon_en = 1'b0;
      checks++; if (dut_low_cnt != 0) begin errors++; $display("FAIL baddev_sda_low got %0d want 0", dut_low_cnt); end
      checks++; if (q_addr.size() != 0) begin errors++; $display("FAIL baddev_strobes got %0d want 0", q_addr.size()); end
      bus_start();
      for (int i = 0; i < 4; i++) begin
         write_byte(good[i], ack);
         checks++; if (ack !== 1'b1) begin errors++; $display("FAIL recover_ack%0d got %b want 1", i, ack); end
      end
      bus_stop();
      wq(4);
      checks++; if (q_addr.size() != 1) begin errors++; $display("FAIL recover_strobes got %0d want 1", q_addr.size()); end
      if (q_addr.size() >= 1) begin
         checks++; if (q_addr[0] !== 16'h1000) begin errors++; $display("FAIL recover_addr got %h want 1000", q_addr[0]); end
         checks++; if (q_data[0] !== 8'hA5) begin errors++; $display("FAIL recover_data got %h want a5", q_data[0]); end
      end
   endtask

   task automatic test_partial_stop;
      logic [7:0] v[3];
      logic       ack;
      v = '{8'h78, 8'h30, 8'h08};
      q_addr.delete(); q_data.delete();
      bus_start();
      for (int i = 0; i < 3; i++) begin
         write_byte(v[i], ack);
         checks++; if (ack !== 1'b1) begin errors++; $display("FAIL partial_ack%0d got %b want 1", i, ack); end
      end
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
      bus_stop();
      wq(4);
      checks++; if (q_addr.size() != 0) begin errors++; $display("FAIL partial_strobes got %0d want 0", q_addr.size()); end
      checks++; if (dut.r_state !== S_IDLE) begin errors++; $display("FAIL partial_state got %0d want %0d", dut.r_state, S_IDLE); end
      checks++; if (dut.r_regfile[8'h08] !== 8'h82) begin errors++; $display("FAIL partial_reg got %h want 82", dut.r_regfile[8'h08]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_ack;
      logic [7:0] v;
      v = 8'h78;
      bus_start();
      for (int i = 7; i >= 0; i--) write_bit(v[i]);
      m_oe = 1'b0;
      wq(2);
      checks++; if (sda !== 1'b0) begin errors++; $display("FAIL midack_driven got %b want 0", sda); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midack_busy got %b want 1", busy); end
      sys_rstn = 1'b0;
      #1;
      checks++; if (sda !== 1'b1) begin errors++; $display("FAIL midack_release got %b want 1", sda); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midack_busy_rst got %b want 0", busy); end
      checks++; if (reg_wr_addr !== 16'h0000) begin errors++; $display("FAIL midack_addr got %h want 0000", reg_wr_addr); end
      checks++; if (reg_wr_data !== 8'h00) begin errors++; $display("FAIL midack_data got %h want 00", reg_wr_data); end
      checks++; if (reg_wr_en !== 1'b0) begin errors++; $display("FAIL midack_wr_en got %b want 0", reg_wr_en); end
      checks++; if (dut.r_regfile[8'h08] !== 8'h00) begin errors++; $display("FAIL midack_reg08 got %h want 00", dut.r_regfile[8'h08]); end
      checks++; if (dut.r_regfile[8'hFF] !== 8'h00) begin errors++; $display("FAIL midack_regff got %h want 00", dut.r_regfile[8'hFF]); end
      checks++; if (dut.r_regfile[8'h00] !== 8'h00) begin errors++; $display("FAIL midack_reg00 got %h want 00", dut.r_regfile[8'h00]); end
      wq(4);
      sys_rstn = 1'b1;
      wq(4);
      scl = 1'b1;
      wq(Q);
   endtask

   task automatic test_read;
      logic [7:0] v[3];
      logic       ack;
      v = '{8'h78, 8'h30, 8'h08};
`ifdef SCCB_SLAVE_READ_EN
      logic [7:0] d0;
      logic [7:0] d1;
      bus_start();
      for (int i = 0; i < 3; i++) write_byte(v[i], ack);
      write_byte(8'h5A, ack);
      bus_stop();
      bus_start();
      for (int i = 0; i < 3; i++) begin
         write_byte(v[i], ack);
         checks++; if (ack !== 1'b1) begin errors++; $display("FAIL read_setup_ack%0d got %b want 1", i, ack); end
      end
      bus_start();
      write_byte(8'h79, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL read_dev_ack got %b want 1", ack); end
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      checks++; if (d0 !== 8'h5A) begin errors++; $display("FAIL read_byte0 got %h want 5a", d0); end
      checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL read_byte1 got %h want 00", d1); end
`else
      bus_start();
      for (int i = 0; i < 3; i++) begin
         write_byte(v[i], ack);
         checks++; if (ack !== 1'b1) begin errors++; $display("FAIL read_setup_ack%0d got %b want 1", i, ack); end
      end
      bus_start();
      write_byte(8'h79, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL read_dev_nack got %b want 0", ack); end
`endif
      checks++; if (dut.r_state !== S_WAIT_STOP) begin errors++; $display("FAIL read_wait_stop got %0d want %0d", dut.r_state, S_WAIT_STOP); end
      bus_stop();
      wq(4);
      checks++; if (dut.r_state !== S_IDLE) begin errors++; $display("FAIL read_idle got %0d want %0d", dut.r_state, S_IDLE); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_burst_wrap();
      test_bad_device();
      test_partial_stop();
      test_reset_mid_ack();
      test_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
